seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed 7-segment digits, 1..8.
REQ-002 SHALL have parameter WIDTH, default 14: binary input width; 2^WIDTH-1 >= 10^DIGITS-1.
REQ-003 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit stays enabled, >= 1.
REQ-004 SHALL have port clk  in  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  in  1  request to convert value; accepted only when busy=0.
REQ-007 SHALL have port value  in  WIDTH  unsigned binary number to display.
REQ-008 SHALL have port busy  out  1  conversion in progress.
REQ-009 SHALL have port overflow  out  1  last accepted value exceeded 10^DIGITS-1.
REQ-010 SHALL have port seg  out  7  segments, active-high; seg[6]=A ... seg[0]=G.
REQ-011 SHALL have port an  out  DIGITS  digit enables, active-low, one-hot; an[0] = least significant digit.

Function
REQ-012 Load SHALL be accepted on a rising edge with load=1 and busy=0, capturing value; load while busy=1 SHALL be ignored with no effect.
REQ-013 busy SHALL rise on the edge that accepts load and stay high for exactly WIDTH cycles: states IDLE -> CONV (WIDTH shift-add-3 iterations, double-dabble) -> IDLE.
REQ-014 On the edge busy falls, the display BCD register and overflow SHALL update together; the displayed digits SHALL keep the previous value throughout CONV.
REQ-015 If the captured value > 10^DIGITS-1, overflow SHALL be 1 and every digit SHALL show dash (seg=7'h01); otherwise overflow SHALL be 0.
REQ-016 Digit encoding SHALL be 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B (hex, seg[6:0]).
REQ-017 Leading-zero blanking: any digit above the most significant nonzero digit SHALL output seg=7'h00; digit 0 SHALL always be shown (value 0 displays "0").
REQ-018 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the scan index SHALL advance by 1, wrapping from DIGITS-1 to 0.
REQ-019 an and seg SHALL be registered and change on the same edge; an SHALL have exactly one bit low at any time after the first post-reset edge.
REQ-020 Scanning SHALL continue uninterrupted during CONV and on load acceptance; load SHALL NOT reset the refresh counter or scan index.
REQ-021 A new load SHALL be accepted on the first edge at which busy=0 is sampled, i.e. the edge after the edge on which busy fell.

Reset
REQ-022 While rst_n=0: busy=0, overflow=0, seg=7'h00, an=all ones, BCD register=0, refresh counter=0, scan index=0, state=IDLE.
REQ-023 Reset asserted mid-conversion SHALL abort it; the display SHALL show the value 0 after release, not the partial result.
REQ-024 On the first edge after release: an[0]=0, seg=7'h7E.

Verification (DIGITS=4, WIDTH=14, REFRESH_DIV=4)
REQ-025 Reset release, no load -> an cycles 1110,1101,1011,0111,1110, 4 cycles each; seg=7E on an=1110, 00 otherwise.
REQ-026 load value=1234 -> busy high 14 cycles; then digits 0..3 show 33,79,6D,30; overflow=0.
REQ-027 load value=7 -> digit0=70, digits1-3=00; load value=0 -> digit0=7E, others 00.
REQ-028 load value=10000 -> overflow=1, all four digits 01; following load value=5 -> overflow=0, digit0=5B.
REQ-029 load value=1234, then load value=9999 pulsed during busy -> second ignored; display 1234; load value=9999 on the edge after busy falls -> accepted, all digits 7B.
REQ-030 rst_n low at cycle 5 of a 1234 conversion -> busy=0, an=1111 immediately; after release, display shows "0", not 1234.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - binary to multiplexed 7-segment display driver
//
// Converts an unsigned binary value to BCD with a shift-add-3 (double-dabble)
// engine, one iteration per clock, and scans the result across DIGITS
// common-anode style digits with leading-zero blanking and an overflow dash.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   load      - request to convert value (taken only while busy is low)
//   value     - unsigned binary number to display
//   busy      - conversion in progress
//   overflow  - last accepted value exceeded 10^DIGITS-1
//   seg       - segments A..G on seg[6]..seg[0], active-high
//   an        - digit enables, active-low one-hot, an[0] = least significant

module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  value,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(10 ** DIGITS - 1);

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    // Conversion engine state
    state_t           state_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]    work_q;
    logic [CW-1:0]    iter_q;
    logic             ovf_pend_q;
    logic             busy_q;

    // Displayed result
    logic [BW-1:0]    disp_q;
    logic             overflow_q;

    // Scanner state
    logic [RW-1:0]    ref_q;
    logic [SW-1:0]    scan_q;
    logic [DIGITS-1:0] an_q;
    logic [6:0]       seg_q;

    // Next-state signals
    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_d;
    logic [WIDTH-1:0] bin_d;
    logic [DIGITS-1:0] an_d;
    logic [6:0]       seg_d;
    logic [3:0]       nib;
    logic             any_nz;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h7E;
            4'd1:    enc = 7'h30;
            4'd2:    enc = 7'h6D;
            4'd3:    enc = 7'h79;
            4'd4:    enc = 7'h33;
            4'd5:    enc = 7'h5B;
            4'd6:    enc = 7'h5F;
            4'd7:    enc = 7'h70;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h7B;
            default: enc = 7'h00;
        endcase
    endfunction

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift the
    // combined {bcd, bin} register left by one. BCD digits above DIGITS are
    // not kept; carries only travel upward so the retained digits stay exact.
    always_comb begin
        adj = work_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        work_d = BW'({adj, bin_q[WIDTH-1]});
        bin_d  = {bin_q[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            work_q     <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        bin_q      <= value;
                        work_q     <= '0;
                        iter_q     <= '0;
                        ovf_pend_q <= (value > MAX_VAL);
                        busy_q     <= 1'b1;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    bin_q  <= bin_d;
                    work_q <= work_d;
                    iter_q <= iter_q + 1'b1;
                    // Last iteration: publish digits and overflow together
                    if (iter_q == CW'(WIDTH - 1)) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        disp_q     <= work_d;
                        overflow_q <= ovf_pend_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Walk from the top digit down so any_nz tells whether this digit or any
    // more significant one is nonzero; digit 0 is never blanked.
    always_comb begin
        an_d   = '1;
        seg_d  = 7'h00;
        nib    = 4'd0;
        any_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz = any_nz | (disp_q[4*i +: 4] != 4'd0);
            if (scan_q == SW'(i)) begin
                an_d[i] = 1'b0;
                nib     = disp_q[4*i +: 4];
                if (overflow_q) begin
                    seg_d = 7'h01;
                end else if (any_nz || (i == 0)) begin
                    seg_d = enc(nib);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q  <= '0;
            scan_q <= '0;
            an_q   <= '1;
            seg_q  <= 7'h00;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            if (ref_q == RW'(REFRESH_DIV - 1)) begin
                ref_q  <= '0;
                scan_q <= (scan_q == SW'(DIGITS - 1)) ? '0 : scan_q + 1'b1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule
